// File: rtl/mem_access_ctrl_pkg.sv
// Data-bus payload types shared by the memory-stage access controller and its bench.
package mem_access_ctrl_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] addr;
        logic [2:0]        size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory-stage data-bus sequencer: one outstanding load/store, store lane steering, load align/extend.
// Optional macro MISALIGN_TRAP_EN: misaligned requests complete immediately with a misalign pulse.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = DATA_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [2:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output dbus_req_t       dreq,
    input  dbus_resp_t      dresp,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rdata
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);

    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state;
    state_t            stateNext;
    logic              latchReq;
    logic              capture;
    logic              trapReq;
    logic              misaligned;
    logic [OFF_W-1:0]  lowMask;
    logic [LANES-1:0]  sizeStrb;
    logic [XLEN-1:0]   busAddr;
    logic [OFF_W-1:0]  reqOff;
    logic [LANES-1:0]  storeStrb;
    logic [XLEN-1:0]   storeData;
    logic [XLEN-1:0]   loadShifted;
    logic [XLEN-1:0]   loadData;
    logic              isWrite;
    logic              isUnsigned;

    // Request decode: size mask, bus address and lane-shifted store payload.
    always_comb begin
        lowMask  = '1;
        sizeStrb = '1;
        case (req_size)
            3'd0: begin lowMask = '0;        sizeStrb = LANES'(8'h01); end
            3'd1: begin lowMask = OFF_W'(1); sizeStrb = LANES'(8'h03); end
            3'd2: begin lowMask = OFF_W'(3); sizeStrb = LANES'(8'h0F); end
            default: ;
        endcase
`ifdef MISALIGN_TRAP_EN
        busAddr    = req_addr;
        misaligned = |(req_addr[OFF_W-1:0] & lowMask);
`else
        busAddr    = {req_addr[XLEN-1:OFF_W], req_addr[OFF_W-1:0] & ~lowMask};
        misaligned = 1'b0;
`endif
        reqOff    = busAddr[OFF_W-1:0];
        storeStrb = LANES'(sizeStrb << reqOff);
        storeData = req_wdata << {reqOff, 3'b000};
    end

    // Load path works from the latched request, so it is immune to req_* changes mid-access.
    always_comb begin
        loadShifted = dresp.data >> {dreq.addr[OFF_W-1:0], 3'b000};
        case (dreq.size)
            3'd0: loadData = isUnsigned ? XLEN'(loadShifted[7:0])
                                        : {{(XLEN-8){loadShifted[7]}}, loadShifted[7:0]};
            3'd1: loadData = isUnsigned ? XLEN'(loadShifted[15:0])
                                        : {{(XLEN-16){loadShifted[15]}}, loadShifted[15:0]};
            3'd2: loadData = isUnsigned ? XLEN'(loadShifted[31:0])
                                        : {{(XLEN-32){loadShifted[31]}}, loadShifted[31:0]};
            default: loadData = loadShifted;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next state, handshake strobes and pipeline stall.
    always_comb begin
        stateNext = state;
        latchReq  = 1'b0;
        capture   = 1'b0;
        trapReq   = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    if (misaligned) begin
                        trapReq   = 1'b1;
                        stateNext = DONE;
                    end else begin
                        latchReq  = 1'b1;
                        stateNext = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dresp.addr_ok) begin
                    capture   = dresp.data_ok;
                    stateNext = dresp.data_ok ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dresp.data_ok) begin
                    capture   = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dreq       <= '0;
            done       <= 1'b0;
            rdata      <= '0;
            isWrite    <= 1'b0;
            isUnsigned <= 1'b0;
        end else begin
            dreq.valid <= (stateNext == REQ);
            done       <= (stateNext == DONE);
            if (latchReq) begin
                dreq.addr   <= busAddr;
                dreq.size   <= req_size;
                dreq.strobe <= req_write ? storeStrb : '0;
                dreq.data   <= req_write ? storeData : '0;
                isWrite     <= req_write;
                isUnsigned  <= req_unsigned;
            end
            if (capture && !isWrite) rdata <= loadData;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign <= 1'b0;
        else       misalign <= trapReq;
    end
`else
    logic unusedTrap;
    assign unusedTrap = trapReq;
`endif

endmodule
